// File: rtl/sc_lives_levels_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sc_game_pkg
//  Description : Constants and types shared between the Frogger game FSM and
//                its lives/levels bookkeeping stage. This includes default
//                counter sizing and limits, plus the strobe edge-detector
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_game_pkg;

    // Default counter sizing and limits
    localparam int DEFAULT_LIVES_W     = 3;
    localparam int DEFAULT_LEVEL_W     = 3;
    localparam int DEFAULT_INIT_LIVES  = 3;
    localparam int DEFAULT_MAX_LIVES   = 7;
    localparam int DEFAULT_MAX_LEVEL   = 5;
    localparam int DEFAULT_BONUS_EVERY = 2;

    // Per-strobe edge detector states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } edge_state_t;

endpackage : sc_game_pkg
`default_nettype wire

// File: rtl/sc_lives_levels_counter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sc_lives_levels_counter_if
//  Description : Handshake between the general game FSM and the lives/levels
//                counter.
//                master : game FSM side. It drives the active-low strobes and
//                         reads back the flags and counts.
//                slave  : counter side.
//  Signals     : SC_LIVESLEVELS_clear_InLow            reload request (act-low)
//                SC_LIVESLEVELS_contador_vidas_InLow   lose-one-life strobe
//                SC_LIVESLEVELS_contador_niveles_InLow advance-level strobe
//                SC_LIVESLEVELS_COMPARATOR_LIVES       1 = lives exhausted
//                SC_LIVESLEVELS_COMPARATOR_LEVELS      0 = last level reached
//                SC_LIVESLEVELS_lives_Out              current lives
//                SC_LIVESLEVELS_level_Out              current level
//  Revision    : 1.0 - initial release
// ============================================================================
interface sc_lives_levels_counter_if
    import sc_game_pkg::*;
#(
    parameter int LIVES_W = DEFAULT_LIVES_W,
    parameter int LEVEL_W = DEFAULT_LEVEL_W
);

    logic               SC_LIVESLEVELS_clear_InLow;
    logic               SC_LIVESLEVELS_contador_vidas_InLow;
    logic               SC_LIVESLEVELS_contador_niveles_InLow;
    logic               SC_LIVESLEVELS_COMPARATOR_LIVES;
    logic               SC_LIVESLEVELS_COMPARATOR_LEVELS;
    logic [LIVES_W-1:0] SC_LIVESLEVELS_lives_Out;
    logic [LEVEL_W-1:0] SC_LIVESLEVELS_level_Out;

    modport master (
        output SC_LIVESLEVELS_clear_InLow,
        output SC_LIVESLEVELS_contador_vidas_InLow,
        output SC_LIVESLEVELS_contador_niveles_InLow,
        input  SC_LIVESLEVELS_COMPARATOR_LIVES,
        input  SC_LIVESLEVELS_COMPARATOR_LEVELS,
        input  SC_LIVESLEVELS_lives_Out,
        input  SC_LIVESLEVELS_level_Out
    );

    modport slave (
        input  SC_LIVESLEVELS_clear_InLow,
        input  SC_LIVESLEVELS_contador_vidas_InLow,
        input  SC_LIVESLEVELS_contador_niveles_InLow,
        output SC_LIVESLEVELS_COMPARATOR_LIVES,
        output SC_LIVESLEVELS_COMPARATOR_LEVELS,
        output SC_LIVESLEVELS_lives_Out,
        output SC_LIVESLEVELS_level_Out
    );

endinterface : sc_lives_levels_counter_if
`default_nettype wire

// File: rtl/sc_lives_levels_counter_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sc_strobe_edge_detect
//  Description : Turns an active-low strobe into a single event. The event is
//                asserted on the clock edge where the strobe is first sampled
//                low. A strobe held low for any number of cycles yields
//                exactly one event.
//  Ports       : clk          clock
//                rst          asynchronous active-high reset
//                strobe_n     active-low strobe (same clock domain)
//                strobe_event combinational event, consumed on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_strobe_edge_detect
    import sc_game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic strobe_event
);

    edge_state_t r_state;
    edge_state_t w_state_nxt;
    logic        r_hist;

    // History resets to 1 (idle). A strobe that is still low when reset is
    // released is therefore seen as a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hist  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= strobe_n;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        strobe_event = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!strobe_n && r_hist) begin
                    w_state_nxt  = ST_ARMED;
                    strobe_event = 1'b1;
                end
            end
            ST_ARMED: begin
                if (strobe_n) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : sc_strobe_edge_detect
`default_nettype wire

// File: rtl/sc_lives_levels_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sc_lives_levels_counter
//  Description : Lives and level bookkeeping for the Frogger game controller.
//                It counts falling edges of the game FSM's active-low
//                strobes. It also returns the comparator flags that the FSM
//                uses to choose between continue, lose and win.
//  Ports       : SC_LIVESLEVELS_CLOCK_50      50 MHz system clock
//                SC_LIVESLEVELS_RESET_InHigh  asynchronous active-high reset
//                bus (slave modport)          strobes in; flags and counts out
//  Options     : SC_LIVESLEVELS_BONUS_LIFE_EN - when defined, one bonus life is
//                granted each time a level event advances the level to a
//                multiple of BONUS_EVERY. The bonus saturates at MAX_LIVES.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_lives_levels_counter
    import sc_game_pkg::*;
#(
    parameter int LIVES_W     = DEFAULT_LIVES_W,
    parameter int LEVEL_W     = DEFAULT_LEVEL_W,
    parameter int INIT_LIVES  = DEFAULT_INIT_LIVES,
    parameter int MAX_LEVEL   = DEFAULT_MAX_LEVEL
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
    ,
    parameter int MAX_LIVES   = DEFAULT_MAX_LIVES,
    parameter int BONUS_EVERY = DEFAULT_BONUS_EVERY
`endif
)
(
    input  logic                      SC_LIVESLEVELS_CLOCK_50,
    input  logic                      SC_LIVESLEVELS_RESET_InHigh,
    sc_lives_levels_counter_if.slave  bus
);

    localparam logic [LIVES_W-1:0] C_INIT_LIVES = LIVES_W'(INIT_LIVES);
    localparam logic [LEVEL_W-1:0] C_MAX_LEVEL  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] C_LEVEL_ONE  = LEVEL_W'(1);
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
    localparam logic [LIVES_W-1:0] C_MAX_LIVES  = LIVES_W'(MAX_LIVES);
    localparam logic [LEVEL_W-1:0] C_BONUS_EVERY = LEVEL_W'(BONUS_EVERY);
`endif

    logic               w_ev_lives;
    logic               w_ev_level;
    logic [LIVES_W-1:0] r_lives;
    logic [LEVEL_W-1:0] r_level;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [LIVES_W-1:0] w_lives_dec;
    logic               w_level_adv;

    // ------------------------------------------------------------------
    // Strobe event detection
    // ------------------------------------------------------------------
    sc_strobe_edge_detect u_edge_vidas (
        .clk          (SC_LIVESLEVELS_CLOCK_50),
        .rst          (SC_LIVESLEVELS_RESET_InHigh),
        .strobe_n     (bus.SC_LIVESLEVELS_contador_vidas_InLow),
        .strobe_event (w_ev_lives)
    );

    sc_strobe_edge_detect u_edge_niveles (
        .clk          (SC_LIVESLEVELS_CLOCK_50),
        .rst          (SC_LIVESLEVELS_RESET_InHigh),
        .strobe_n     (bus.SC_LIVESLEVELS_contador_niveles_InLow),
        .strobe_event (w_ev_level)
    );

    // ------------------------------------------------------------------
    // Next-count logic. A clear request overrides both events. The edge
    // detectors keep tracking history regardless, so a strobe held across
    // a clear is not counted once the clear is released.
    // ------------------------------------------------------------------
    always_comb begin
        w_lives_nxt = r_lives;
        w_level_nxt = r_level;
        w_lives_dec = r_lives;
        w_level_adv = 1'b0;

        if (!bus.SC_LIVESLEVELS_clear_InLow) begin
            w_lives_nxt = C_INIT_LIVES;
            w_level_nxt = C_LEVEL_ONE;
        end else begin
            if (w_ev_lives && (r_lives != '0)) begin
                w_lives_dec = r_lives - LIVES_W'(1);
            end
            if (w_ev_level && (r_level != C_MAX_LEVEL)) begin
                w_level_nxt = r_level + C_LEVEL_ONE;
                w_level_adv = 1'b1;
            end
            w_lives_nxt = w_lives_dec;
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
            // The decrement is applied first, so a simultaneous loss and
            // bonus nets to zero unless a clamp is hit.
            if (w_level_adv && ((w_level_nxt % C_BONUS_EVERY) == '0)
                && (w_lives_dec < C_MAX_LIVES)) begin
                w_lives_nxt = w_lives_dec + LIVES_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge SC_LIVESLEVELS_CLOCK_50 or posedge SC_LIVESLEVELS_RESET_InHigh) begin
        if (SC_LIVESLEVELS_RESET_InHigh) begin
            r_lives <= C_INIT_LIVES;
            r_level <= C_LEVEL_ONE;
        end else begin
            r_lives <= w_lives_nxt;
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Flags decode the registered counts. This makes them follow reset
    // asynchronously and gives them a one-clock delay from the strobe sample.
    // ------------------------------------------------------------------
    assign bus.SC_LIVESLEVELS_COMPARATOR_LIVES  = (r_lives == '0);
    assign bus.SC_LIVESLEVELS_COMPARATOR_LEVELS = (r_level != C_MAX_LEVEL);
    assign bus.SC_LIVESLEVELS_lives_Out         = r_lives;
    assign bus.SC_LIVESLEVELS_level_Out         = r_level;

endmodule : sc_lives_levels_counter
`default_nettype wire

// File: tb/tb_sc_lives_levels_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_lives_levels_counter
//  Description : Directed self-checking bench for sc_lives_levels_counter.
//                Each step pushes the expected counts and flags onto a
//                scoreboard queue. The entry is popped and compared after the
//                clock edge that applies the step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_lives_levels_counter;
    import sc_game_pkg::*;

    localparam int INIT_L = 3;
    localparam int MAXLV  = 5;
    localparam int MAXLI  = 7;
    localparam int BON    = 2;
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
    localparam bit BONUS  = 1'b1;
`else
    localparam bit BONUS  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_lives_levels_counter_if bus ();

    sc_lives_levels_counter dut (
        .SC_LIVESLEVELS_CLOCK_50     (clk),
        .SC_LIVESLEVELS_RESET_InHigh (rst),
        .bus                         (bus)
    );

    typedef struct {
        string tag;
        int    lives;
        int    level;
        logic  cl;
        logic  cv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_lives;
    int   m_level;
    bit   m_hv;
    bit   m_hn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lives = INIT_L;
        m_level = 1;
        m_hv    = 1'b1;
        m_hn    = 1'b1;
    endtask

    // Drive one cycle of inputs, predict its effect, then compare after the edge.
    task automatic step(input string tag, input logic clr, input logic v, input logic n);
        exp_t e;
        bit   ev_v;
        bit   ev_n;
        bit   adv;
        @(negedge clk);
        bus.SC_LIVESLEVELS_clear_InLow            = clr;
        bus.SC_LIVESLEVELS_contador_vidas_InLow   = v;
        bus.SC_LIVESLEVELS_contador_niveles_InLow = n;
        ev_v = !v && m_hv;
        ev_n = !n && m_hn;
        m_hv = v;
        m_hn = n;
        adv  = 1'b0;
        if (!clr) begin
            m_lives = INIT_L;
            m_level = 1;
        end else begin
            if (ev_v && m_lives > 0) m_lives--;
            if (ev_n && m_level < MAXLV) begin
                m_level++;
                adv = 1'b1;
            end
            if (BONUS && adv && (m_level % BON == 0) && m_lives < MAXLI) m_lives++;
        end
        e.tag   = tag;
        e.lives = m_lives;
        e.level = m_level;
        e.cl    = (m_lives == 0);
        e.cv    = (m_level != MAXLV);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".lives"}, 32'(bus.SC_LIVESLEVELS_lives_Out), 32'(e.lives));
        check({e.tag, ".level"}, 32'(bus.SC_LIVESLEVELS_level_Out), 32'(e.level));
        check({e.tag, ".cmp_lives"}, 32'(bus.SC_LIVESLEVELS_COMPARATOR_LIVES), 32'(e.cl));
        check({e.tag, ".cmp_levels"}, 32'(bus.SC_LIVESLEVELS_COMPARATOR_LEVELS), 32'(e.cv));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".lives"}, 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd3);
        check({tag, ".level"}, 32'(bus.SC_LIVESLEVELS_level_Out), 32'd1);
        check({tag, ".cmp_lives"}, 32'(bus.SC_LIVESLEVELS_COMPARATOR_LIVES), 32'd0);
        check({tag, ".cmp_levels"}, 32'(bus.SC_LIVESLEVELS_COMPARATOR_LEVELS), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.SC_LIVESLEVELS_clear_InLow            = 1'b1;
        bus.SC_LIVESLEVELS_contador_vidas_InLow   = 1'b1;
        bus.SC_LIVESLEVELS_contador_niveles_InLow = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Lives: three 5-cycle low pulses bring 3 -> 0, a fourth does nothing.
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 5; c++) step($sformatf("vidas_p%0d_c%0d", p, c), 1'b1, 1'b0, 1'b1);
            if (p == 2) check("lives_exhausted_flag", 32'(bus.SC_LIVESLEVELS_COMPARATOR_LIVES), 32'd1);
            step($sformatf("vidas_p%0d_rel", p), 1'b1, 1'b1, 1'b1);
        end
        check("lives_floor", 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd0);

        // Levels: four pulses reach MAX_LEVEL, a fifth is ignored.
        for (int p = 0; p < 5; p++) begin
            step($sformatf("niveles_p%0d", p), 1'b1, 1'b1, 1'b0);
            step($sformatf("niveles_p%0d_rel", p), 1'b1, 1'b1, 1'b1);
        end
        check("level_ceiling", 32'(bus.SC_LIVESLEVELS_level_Out), 32'd5);
        check("level_won_flag", 32'(bus.SC_LIVESLEVELS_COMPARATOR_LEVELS), 32'd0);

        // Simultaneous events starting from lives=2, level=2 (without bonus).
        step("clear_a", 1'b0, 1'b1, 1'b1);
        step("clear_a_rel", 1'b1, 1'b1, 1'b1);
        step("set_v", 1'b1, 1'b0, 1'b1);
        step("set_v_rel", 1'b1, 1'b1, 1'b1);
        step("set_n", 1'b1, 1'b1, 1'b0);
        step("set_n_rel", 1'b1, 1'b1, 1'b1);
        step("both", 1'b1, 1'b0, 1'b0);
        if (!BONUS) begin
            check("both_lives", 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd1);
            check("both_level", 32'(bus.SC_LIVESLEVELS_level_Out), 32'd3);
        end
        step("both_rel", 1'b1, 1'b1, 1'b1);

        // Clear wins over both strobes; held strobes do not re-fire afterwards.
        step("set_n4", 1'b1, 1'b1, 1'b0);
        step("set_n4_rel", 1'b1, 1'b1, 1'b1);
        step("clear_both", 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step($sformatf("held_after_clear_%0d", c), 1'b1, 1'b0, 1'b0);
        check("clear_lives", 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd3);
        check("clear_level", 32'(bus.SC_LIVESLEVELS_level_Out), 32'd1);
        step("clear_rel", 1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a held strobe.
        step("pre_rst_v", 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_reset_values("async_reset");
        rst = 1'b0;
        step("post_rst_v", 1'b1, 1'b0, 1'b1);
        check("post_rst_lives", 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd2);
        step("post_rst_rel", 1'b1, 1'b1, 1'b1);

`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
        step("b_clear", 1'b0, 1'b1, 1'b1);
        step("b_clear_rel", 1'b1, 1'b1, 1'b1);
        step("b_v", 1'b1, 1'b0, 1'b1);
        step("b_v_rel", 1'b1, 1'b1, 1'b1);
        step("b_n2", 1'b1, 1'b1, 1'b0);
        check("bonus_lives", 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd3);
        step("b_n2_rel", 1'b1, 1'b1, 1'b1);
        step("b_n3", 1'b1, 1'b1, 1'b0);
        step("b_n3_rel", 1'b1, 1'b1, 1'b1);
        step("b_both", 1'b1, 1'b0, 1'b0);
        check("bonus_net_zero", 32'(bus.SC_LIVESLEVELS_lives_Out), 32'd3);
        check("bonus_level4", 32'(bus.SC_LIVESLEVELS_level_Out), 32'd4);
        step("b_both_rel", 1'b1, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sc_lives_levels_counter
`default_nettype wire
